// File: rtl/timer_counter_pkg.sv
// timer_counter_pkg: shared constants for the countdown timer on the peripheral bridge.
// Holds register offsets, CTRL bit positions, mode codes, FSM encodings and the HWInt slot.
// Also a byte-merge helper used for byte-enabled register writes (TC_BYTE_WE_EN builds).
package timer_counter_pkg;

  localparam int TC_DATA_W = 32;

  // Register offsets, decoded from Addr[3:2]
  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // Mode codes; 2'b10 and 2'b11 decode as one-shot
  localparam logic [1:0] TC_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] TC_MODE_AUTO    = 2'b01;

  // HWInt bit the bridge wires this timer's IRQ onto
  localparam int TC_HWINT_BIT = 2;

  typedef enum logic [1:0] {
    TC_ST_IDLE = 2'd0,
    TC_ST_LOAD = 2'd1,
    TC_ST_CNT  = 2'd2,
    TC_ST_INT  = 2'd3
  } tc_state_e;

  // Replace only the bytes of old_val whose enable bit is set
  function automatic logic [31:0] tc_byte_merge(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// timer_counter_if: bridge-side register bus plus interrupt line of the timer.
// Ports: Addr[31:2], WE, Din (bridge -> timer); Dout, IRQ (timer -> bridge/CP0).
// Optional TC_BYTE_WE_EN adds BE[3:0] byte enables driven by the bridge.
interface timer_counter_if;
  import timer_counter_pkg::*;

  logic [31:2]          Addr;
  logic                 WE;
  logic [TC_DATA_W-1:0] Din;
  logic [TC_DATA_W-1:0] Dout;
  logic                 IRQ;
`ifdef TC_BYTE_WE_EN
  logic [3:0]           BE;
`endif

  modport master (
    output Addr, WE, Din,
`ifdef TC_BYTE_WE_EN
    output BE,
`endif
    input  Dout, IRQ
  );

  modport slave (
    input  Addr, WE, Din,
`ifdef TC_BYTE_WE_EN
    input  BE,
`endif
    output Dout, IRQ
  );

endinterface

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped countdown timer; IRQ feeds one CP0 HWInt bit.
// Ports: clk, reset (synchronous, active-high), bus (slave): Addr/WE/Din in, Dout/IRQ out.
// Latency: writes land on the strobed edge, Dout/IRQ are combinational; no backpressure.
// Optional TC_BYTE_WE_EN: CTRL/PRESET writes honour bus.BE; default build does full-word writes.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] RESET_PRESET = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  timer_counter_if.slave bus
);

  logic [3:0]  ctrl_q;
  logic [31:0] preset_q;
  logic [31:0] count_q;
  logic [31:0] count_d;
  logic        irq_flag_q;
  tc_state_e   state_q;
  tc_state_e   state_d;

  logic [3:0]  be;
  logic [1:0]  reg_sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        wr_clears;
  logic        enable;
  logic        auto_mode;
  logic        set_irq;
  logic        auto_clr;
  logic        en_clr;

`ifdef TC_BYTE_WE_EN
  assign be = bus.BE;
`else
  assign be = 4'hF;
`endif

  // Only Addr[3:2] are decoded; the upper word-address bits are don't-care
  logic unused_addr;
  assign unused_addr = ^bus.Addr[31:4];

  assign reg_sel   = bus.Addr[3:2];
  assign wr_ctrl   = bus.WE && (reg_sel == TC_CTRL);
  assign wr_preset = bus.WE && (reg_sel == TC_PRESET);
  // An all-zero byte-enable write touches nothing, so it must not ack the interrupt
  assign wr_clears = (wr_ctrl || wr_preset) && (be != 4'h0);
  assign enable    = ctrl_q[CTRL_EN_BIT];
  assign auto_mode = (ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB] == TC_MODE_AUTO);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    set_irq  = 1'b0;
    auto_clr = 1'b0;
    en_clr   = 1'b0;
    case (state_q)
      TC_ST_IDLE: begin
        if (enable) state_d = TC_ST_LOAD;
      end
      TC_ST_LOAD: begin
        count_d = preset_q;
        state_d = TC_ST_CNT;
      end
      TC_ST_CNT: begin
        if (!enable) begin
          state_d = TC_ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // PRESET of 0 lands here on the first count cycle, same as PRESET of 1
          count_d = 32'd0;
          set_irq = 1'b1;
          state_d = TC_ST_INT;
        end
      end
      TC_ST_INT: begin
        state_d = TC_ST_IDLE;
        if (auto_mode) auto_clr = 1'b1;
        else           en_clr   = 1'b1;
      end
      default: state_d = TC_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q     <= 4'h0;
      preset_q   <= RESET_PRESET;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
      state_q    <= TC_ST_IDLE;
    end else begin
      state_q <= state_d;
      count_q <= count_d;

      // A software CTRL write overrides the one-shot auto-disable on the same edge
      if (wr_ctrl && be[0]) ctrl_q <= bus.Din[3:0];
      else if (en_clr)      ctrl_q[CTRL_EN_BIT] <= 1'b0;

      if (wr_preset) preset_q <= tc_byte_merge(preset_q, bus.Din, be);

      // Setting takes priority over a same-edge ack so an interrupt is never dropped
      if (set_irq)                    irq_flag_q <= 1'b1;
      else if (wr_clears || auto_clr) irq_flag_q <= 1'b0;
    end
  end

  always_comb begin
    bus.Dout = 32'd0;
    case (reg_sel)
      TC_CTRL:   bus.Dout = {28'd0, ctrl_q};
      TC_PRESET: bus.Dout = preset_q;
      TC_COUNT:  bus.Dout = count_q;
      default:   bus.Dout = 32'd0;
    endcase
  end

  assign bus.IRQ = irq_flag_q & ctrl_q[CTRL_IM_BIT];

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed-plus-random bench for timer_counter with a timeline reference model.
// Expected IRQ/COUNT values come from closed-form arithmetic on PRESET and edge distance.
// Covers reset, one-shot, auto-reload, IM masking, freeze/reload, races and mid-run reset.
module tb_timer_counter;
  import timer_counter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  timer_counter_if bus();

  timer_counter #(.RESET_PRESET(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // PRESET 0 counts like PRESET 1
  function automatic int eff(input int n);
    return (n == 0) ? 1 : n;
  endfunction

  // COUNT after edge E+j, where E is the enabling write and COUNT was 0 beforehand
  function automatic int exp_count(input int n, input int j);
    int k;
    if (j < 2) return 0;
    k = n - (j - 2);
    return (k > 0) ? k : 0;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    total++;
    assert (bus.IRQ === exp) else begin
      bad++;
      $error("FAIL %s: observed IRQ=%b expected IRQ=%b (cycle %0d)", tag, bus.IRQ, exp, cyc);
    end
  endtask

  // Upper address bits are randomized: only Addr[3:2] may matter
  task automatic set_addr(input logic [1:0] a);
    logic [29:0] r;
    r = 30'($urandom());
    r[1:0] = a;
    bus.Addr = r;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    set_addr(a);
    #1;
    d = bus.Dout;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, output int e);
    @(negedge clk);
    set_addr(a);
    bus.Din = d;
    bus.WE  = 1'b1;
`ifdef TC_BYTE_WE_EN
    bus.BE  = 4'hF;
`endif
    @(posedge clk);
    #1;
    bus.WE = 1'b0;
    e = cyc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic chk_reset_regs(input string tag);
    logic [31:0] v;
    chk_irq({tag, "_irq"}, 1'b0);
    rd(TC_CTRL, v);   check({tag, "_ctrl"}, v, 32'h0);
    rd(TC_PRESET, v); check({tag, "_preset"}, v, 32'h0);
    rd(TC_COUNT, v);  check({tag, "_count"}, v, 32'h0);
    rd(2'd3, v);      check({tag, "_rsvd"}, v, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] v;
    int e, e2, w, n, d, p;

    bus.Addr = '0;
    bus.WE   = 1'b0;
    bus.Din  = '0;
`ifdef TC_BYTE_WE_EN
    bus.BE   = 4'h0;
`endif

    // Reset state and write-ignore behaviour
    do_reset();
    chk_reset_regs("rst");
    wr(TC_COUNT, $urandom(), w);
    rd(TC_COUNT, v);  check("count_ro", v, 32'h0);
    wr(2'd3, $urandom(), w);
    rd(2'd3, v);      check("rsvd_ro", v, 32'h0);
    wr(TC_CTRL, 32'hFFFF_FFF0, w);
    rd(TC_CTRL, v);   check("ctrl_hi_bits", v, 32'h0);
    n = int'($urandom());
    wr(TC_PRESET, 32'(n), w);
    rd(TC_PRESET, v); check("preset_rw", v, 32'(n));

    // One-shot: fixed 5, a random value, and the PRESET=0 corner
    for (int t = 0; t < 3; t++) begin
      n = (t == 0) ? 5 : (t == 1) ? int'($urandom_range(1, 20)) : 0;
      do_reset();
      wr(TC_PRESET, 32'(n), w);
      wr(TC_CTRL, 32'h9, e);
      d = eff(n) + 2;
      for (int j = 1; j <= d + 2; j++) begin
        step(1);
        chk_irq("os_irq", j >= d);
        rd(TC_COUNT, v);
        check("os_count", v, 32'(exp_count(n, j)));
      end
      rd(TC_CTRL, v); check("os_ctrl_en_cleared", v, 32'h8);
      step(3);
      chk_irq("os_irq_held", 1'b1);
      wr(TC_PRESET, 32'(n), w);
      chk_irq("os_irq_ack", 1'b0);
    end

    // Auto-reload: one-cycle pulse every eff(N)+3 cycles
    for (int t = 0; t < 2; t++) begin
      n = (t == 0) ? 3 : int'($urandom_range(0, 6));
      do_reset();
      wr(TC_PRESET, 32'(n), w);
      wr(TC_CTRL, 32'hB, e);
      d = eff(n) + 2;
      p = eff(n) + 3;
      for (int j = 1; j <= d + 3 * p; j++) begin
        step(1);
        chk_irq("ar_pulse", (j >= d) && (((j - d) % p) == 0));
      end
      rd(TC_CTRL, v); check("ar_ctrl_kept", v, 32'hB);
    end

    // IM = 0: flag sets silently, CTRL write clears it before unmasking
    do_reset();
    n = 10;
    wr(TC_PRESET, 32'(n), w);
    wr(TC_CTRL, 32'h1, e);
    d = eff(n) + 2;
    for (int j = 1; j <= d + 2; j++) begin
      step(1);
      chk_irq("im0_irq", 1'b0);
      rd(TC_COUNT, v);
      check("im0_count", v, 32'(exp_count(n, j)));
    end
    rd(TC_CTRL, v); check("im0_ctrl", v, 32'h0);
    wr(TC_CTRL, 32'h8, w);
    chk_irq("im0_unmask", 1'b0);
    step(2);
    chk_irq("im0_unmask_late", 1'b0);

    // Same-edge races: irq set beats a write; bus CTRL beats the auto-disable
    do_reset();
    wr(TC_PRESET, 32'd2, w);
    wr(TC_CTRL, 32'h9, e);
    step(3);
    wr(TC_CTRL, 32'h9, w);
    chk_irq("race_set_wins", 1'b1);
    wr(TC_CTRL, 32'h9, w);
    rd(TC_CTRL, v); check("race_bus_wins", v, 32'h9);
    chk_irq("race_ack", 1'b0);

    // Freeze, PRESET rewrite mid-count, re-enable reloads
    do_reset();
    n = int'($urandom_range(60, 200));
    wr(TC_PRESET, 32'(n), w);
    wr(TC_CTRL, 32'h1, e);
    step(12);
    rd(TC_COUNT, v); check("frz_count_minus10", v, 32'(n - 10));
    wr(TC_PRESET, 32'd7, w);
    rd(TC_COUNT, v); check("frz_preset_no_effect", v, 32'(exp_count(n, w - e)));
    wr(TC_CTRL, 32'h0, w);
    step(3);
    rd(TC_COUNT, v); check("frz_hold", v, 32'(exp_count(n, w - e)));
    step(4);
    rd(TC_COUNT, v); check("frz_hold_late", v, 32'(exp_count(n, w - e)));
    chk_irq("frz_irq", 1'b0);
    wr(TC_CTRL, 32'h1, e2);
    step(2);
    rd(TC_COUNT, v); check("frz_reload", v, 32'd7);

    // Reset mid-count
    do_reset();
    wr(TC_PRESET, 32'd60, w);
    wr(TC_CTRL, 32'h9, e);
    step(12);
    rd(TC_COUNT, v); check("rst_mid_count50", v, 32'd50);
    do_reset();
    chk_reset_regs("rst_mid");

    // Reset with IRQ high
    do_reset();
    wr(TC_PRESET, 32'd2, w);
    wr(TC_CTRL, 32'h9, e);
    step(eff(2) + 2);
    chk_irq("rst_irq_pre", 1'b1);
    do_reset();
    chk_reset_regs("rst_irq");

`ifdef TC_BYTE_WE_EN
    // Byte-enabled PRESET write and the BE=0 no-ack rule
    do_reset();
    wr(TC_PRESET, 32'hFFFF_FFFF, w);
    @(negedge clk);
    set_addr(TC_PRESET);
    bus.Din = 32'h0000_0012;
    bus.BE  = 4'b0001;
    bus.WE  = 1'b1;
    @(posedge clk);
    #1;
    bus.WE = 1'b0;
    rd(TC_PRESET, v); check("be_preset_byte0", v, 32'hFFFF_FF12);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
